// File: rtl/riscv_noc_loopback_pkg.sv
// Shared types and header-field helpers for the NoC loopback endpoint.
// The header swap is written as a function so any flit/field width can reuse it.
package riscv_noc_loopback_pkg;

  localparam int MAX_FLIT_W = 512;
  localparam int IDX_W      = $clog2(MAX_FLIT_W);
  localparam int CLASS_W    = 3;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_BODY,
    RX_SINK
  } rx_state_t;

  function automatic int dest_msb(input int fw);
    return fw - 1;
  endfunction

  // src sits below dest with a CLASS_W-bit class field in between
  function automatic int src_msb(input int fw, input int dw);
    return fw - dw - 1 - CLASS_W;
  endfunction

  function automatic logic [MAX_FLIT_W-1:0] hdr_swap(input logic [MAX_FLIT_W-1:0] flit,
                                                     input int fw, input int dw);
    logic [MAX_FLIT_W-1:0] res;
    res = flit;
    for (int i = 0; i < dw; i++) begin
      res[IDX_W'(dest_msb(fw) - i)]    = flit[IDX_W'(src_msb(fw, dw) - i)];
      res[IDX_W'(src_msb(fw, dw) - i)] = flit[IDX_W'(dest_msb(fw) - i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_noc_loopback_if.sv
// Bundled NoC handshake and status signals between a tile and the loopback.
// slave = loopback side, master = tile/bench side.
interface riscv_noc_loopback_if #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32
);

  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]            in_last;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [CHANNELS*FLIT_WIDTH-1:0] out_flit;
  logic [CHANNELS-1:0]            out_last;
  logic [CHANNELS-1:0]            out_valid;
  logic [CHANNELS-1:0]            out_ready;
  logic [CHANNELS-1:0]            sink;
  logic [CHANNELS*16-1:0]         pkt_count;
  logic [CHANNELS-1:0]            long_pkt_err;

  modport slave (
    input  in_flit, in_last, in_valid, out_ready, sink,
    output in_ready, out_flit, out_last, out_valid, pkt_count, long_pkt_err
  );

  modport master (
    output in_flit, in_last, in_valid, out_ready, sink,
    input  in_ready, out_flit, out_last, out_valid, pkt_count, long_pkt_err
  );

endinterface

// File: rtl/riscv_noc_loopback_channel.sv
// One virtual channel: store-and-forward FIFO with header rewrite, sink mode,
// cut-through fallback for over-long packets, and per-channel counters.
//   state   | meaning
//   RX_HDR  | next accepted flit is a header; sink sampled on acceptance
//   RX_BODY | mid-packet, flits are stored
//   RX_SINK | mid-packet, flits are discarded
module riscv_noc_loopback_channel
  import riscv_noc_loopback_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int DEST_WIDTH = 5,
  parameter int SWAP_HDR   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  sink,
  output logic [15:0]           pkt_count,
  output logic                  long_pkt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef logic [FLIT_WIDTH:0] entry_t;

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cmpl_cnt;
  rx_state_t   rx_state, rx_next;
  logic        cut, err_q;
  logic [15:0] pkt_q;

  logic full, empty, in_hdr, sink_eff, accept, push, pop, head_last, cut_start;
  logic [FLIT_WIDTH-1:0] swapped;
  entry_t wr_entry, head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_HDR;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    in_hdr   = (rx_state == RX_HDR);
    // header flits obey the live sink input; the rest of the packet follows the latched choice
    sink_eff = in_hdr ? sink : (rx_state == RX_SINK);
    in_ready = sink_eff | ~full;
    accept   = in_valid & in_ready;
    push     = accept & ~sink_eff;
    if (accept) begin
      if (in_last)     rx_next = RX_HDR;
      else if (in_hdr) rx_next = sink ? RX_SINK : RX_BODY;
    end
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign swapped  = FLIT_WIDTH'(hdr_swap(MAX_FLIT_W'(in_flit), FLIT_WIDTH, DEST_WIDTH));
  assign wr_entry = {in_last, ((SWAP_HDR != 0) && in_hdr) ? swapped : in_flit};

  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_last = head[FLIT_WIDTH];
  assign out_valid = ~empty & ((cmpl_cnt != '0) | cut);
  assign out_flit  = empty ? '0 : head[FLIT_WIDTH-1:0];
  assign out_last  = ~empty & head_last;
  assign pop       = out_valid & out_ready;

  // a full FIFO with no complete packet can never drain store-and-forward
  assign cut_start = full && (cmpl_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cmpl_cnt <= '0;
      cut      <= 1'b0;
      err_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push & in_last, pop & head_last})
        2'b10:   cmpl_cnt <= cmpl_cnt + PTR_ONE;
        2'b01:   cmpl_cnt <= cmpl_cnt - PTR_ONE;
        default: cmpl_cnt <= cmpl_cnt;
      endcase
      if (pop & head_last) cut <= 1'b0;
      else if (cut_start)  cut <= 1'b1;
      if (cut_start) err_q <= 1'b1;
      if (accept & in_last) pkt_q <= pkt_q + 16'd1;
    end
  end

  assign pkt_count    = pkt_q;
  assign long_pkt_err = err_q;

endmodule

// File: rtl/riscv_noc_loopback.sv
// NoC loopback endpoint for tile benches: one independent channel per
// virtual channel, sliced out of the flattened interface vectors.
module riscv_noc_loopback
  import riscv_noc_loopback_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int DEST_WIDTH = 5,
  parameter int SWAP_HDR   = 1
) (
  input logic                 clk,
  input logic                 rst,
  riscv_noc_loopback_if.slave noc
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    riscv_noc_loopback_channel #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (DEPTH),
      .DEST_WIDTH (DEST_WIDTH),
      .SWAP_HDR   (SWAP_HDR)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .in_flit      (noc.in_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
      .in_last      (noc.in_last[c]),
      .in_valid     (noc.in_valid[c]),
      .in_ready     (noc.in_ready[c]),
      .out_flit     (noc.out_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
      .out_last     (noc.out_last[c]),
      .out_valid    (noc.out_valid[c]),
      .out_ready    (noc.out_ready[c]),
      .sink         (noc.sink[c]),
      .pkt_count    (noc.pkt_count[c*16 +: 16]),
      .long_pkt_err (noc.long_pkt_err[c])
    );
  end

endmodule
